ext_signals_router: RTL and testbench

//  Parametrised successor of the external-signal pad block: one register-programmed router for both directions.

---
 rtl/ext_signals_pkg.sv | 32 +++
 rtl/ext_signals_router_if.sv | 22 ++
 rtl/ext_pad_input_conditioner.sv | 61 ++++++
 rtl/ext_signals_router.sv | 193 +++++++++++++++++++
 tb/tb_ext_signals_router.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_signals_pkg.sv
// Shared types and register map for the external-signal router.
package ext_signals_pkg;

    localparam int unsigned CFG_SEL_W   = 8;

    localparam int unsigned OUTCFG_BASE = 32'h00;
    localparam int unsigned INCFG_BASE  = 32'h40;
    localparam int unsigned STATUS_ADDR = 32'h80;
    localparam int unsigned EDGE_ADDR   = 32'h81;
    localparam int unsigned DEBCFG_ADDR = 32'h82;
    localparam int unsigned ID_ADDR     = 32'hFF;

    localparam logic [15:0] ID_VALUE    = 16'hE510;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } cmd_state_t;

    typedef struct packed {
        logic                 inv;
        logic                 oe;
        logic [CFG_SEL_W-1:0] sel;
    } out_cfg_t;

    typedef struct packed {
        logic                 en;
        logic [CFG_SEL_W-1:0] dest;
    } in_cfg_t;

endpackage

// File: rtl/ext_signals_router_if.sv
// Command frame bus between the command decoder and the router.
interface ext_signals_router_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              enable_cmd;
    logic              write_read;
    logic [ADDR_W-1:0] addr_frame;
    logic [DATA_W-1:0] write_data_frame;
    logic              busy;
    logic [DATA_W-1:0] read_data_frame;

    modport master (
        output enable_cmd, write_read, addr_frame, write_data_frame,
        input  busy, read_data_frame
    );

    modport slave (
        input  enable_cmd, write_read, addr_frame, write_data_frame,
        output busy, read_data_frame
    );
endinterface

// File: rtl/ext_pad_input_conditioner.sv
// Per-pad input conditioning: 2-FF sync, optional debounce, level and rising edge.
// Debounce is built only when EXT_IO_DEBOUNCE_EN is defined.
module ext_pad_input_conditioner #(
    parameter int unsigned DEB_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pad_y,
    input  logic [DEB_W-1:0] deb_thresh,
    output logic             level,
    output logic             rise_c
);

    logic [1:0] sync_q;
    logic       level_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pad_y};
        end
    end

`ifdef EXT_IO_DEBOUNCE_EN
    logic [DEB_W-1:0] cnt_q;
    logic             level_q;

    // Level follows sync only after deb_thresh consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_q[1] == level_q) begin
            cnt_q <= '0;
        end else if ((deb_thresh == '0) || (cnt_q == deb_thresh - DEB_W'(1))) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + DEB_W'(1);
        end
    end

    assign level = level_q;
`else
    logic unused_deb;
    assign unused_deb = ^deb_thresh;
    assign level      = sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= 1'b0;
        end else begin
            level_prev_q <= level;
        end
    end

    assign rise_c = level & ~level_prev_q;

endmodule

// File: rtl/ext_signals_router.sv
// Register-programmed bidirectional pad router between the command bus and PF_IO pads.
// Optional input debounce enabled by defining EXT_IO_DEBOUNCE_EN.
module ext_signals_router
    import ext_signals_pkg::*;
#(
    parameter int unsigned NUM_PADS = 10,
    parameter int unsigned NUM_VEC  = 32,
    parameter int unsigned SEL_W    = CFG_SEL_W,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEB_W    = 8
) (
    input  logic                Clock,
    input  logic                Reset_N,
    ext_signals_router_if.slave cmd,
    input  logic [NUM_VEC-1:0]  EXT_OutputsVectorSignals,
    output logic [NUM_VEC-1:0]  EXT_InputsVectorSignals,
    output logic [NUM_PADS-1:0] IO_Block_D,
    output logic [NUM_PADS-1:0] IO_Block_E,
    input  logic [NUM_PADS-1:0] IO_Block_Y
);

    cmd_state_t        state_q, state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_hold_q;
    int unsigned       a_c;
    logic              wr_en_c;
    logic [DATA_W-1:0] rd_value_c;

    out_cfg_t          out_cfg_q [NUM_PADS];
    in_cfg_t           in_cfg_q  [NUM_PADS];

    logic [NUM_PADS-1:0] level;
    logic [NUM_PADS-1:0] rise_c;
    logic [NUM_PADS-1:0] drive_c;
    logic [NUM_VEC-1:0]  in_or_c;
    logic [DATA_W-1:0]   status_c;
    logic [DATA_W-1:0]   edge_set_c;
    logic [DATA_W-1:0]   edge_clr_c;
    logic [DATA_W-1:0]   edge_q;
    logic [DEB_W-1:0]    deb_thresh;
    logic [DATA_W-1:0]   debcfg_rd_c;

    assign a_c     = 32'(addr_q);
    assign wr_en_c = (state_q == EXEC) && wr_q;

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd.enable_cmd) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read mux over the decoded register address.
    always_comb begin
        rd_value_c = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (a_c == OUTCFG_BASE + p) rd_value_c = DATA_W'(out_cfg_q[p]);
            if (a_c == INCFG_BASE + p)  rd_value_c = DATA_W'(in_cfg_q[p]);
        end
        if (a_c == STATUS_ADDR) rd_value_c = status_c;
        if (a_c == EDGE_ADDR)   rd_value_c = edge_q;
        if (a_c == DEBCFG_ADDR) rd_value_c = debcfg_rd_c;
        if (a_c == ID_ADDR)     rd_value_c = DATA_W'(ID_VALUE);
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            cmd.busy            <= 1'b0;
            cmd.read_data_frame <= '0;
            wr_q                <= 1'b0;
            addr_q              <= '0;
            data_q              <= '0;
            rd_hold_q           <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
                out_cfg_q[p] <= '0;
                in_cfg_q[p]  <= '0;
            end
        end else begin
            cmd.busy <= (state_d != IDLE);
            if ((state_q == IDLE) && cmd.enable_cmd) begin
                wr_q   <= cmd.write_read;
                addr_q <= cmd.addr_frame;
                data_q <= cmd.write_data_frame;
            end
            if (wr_en_c) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    if (a_c == OUTCFG_BASE + p) out_cfg_q[p] <= out_cfg_t'(data_q[SEL_W+1:0]);
                    if (a_c == INCFG_BASE + p)  in_cfg_q[p]  <= in_cfg_t'(data_q[SEL_W:0]);
                end
            end
            if ((state_q == EXEC) && !wr_q) rd_hold_q <= rd_value_c;
            if ((state_q == DONE) && !wr_q) cmd.read_data_frame <= rd_hold_q;
        end
    end

`ifdef EXT_IO_DEBOUNCE_EN
    logic [DEB_W-1:0] deb_cfg_q;

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            deb_cfg_q <= DEB_W'(16);
        end else if (wr_en_c && (a_c == DEBCFG_ADDR)) begin
            deb_cfg_q <= data_q[DEB_W-1:0];
        end
    end

    assign deb_thresh  = deb_cfg_q;
    assign debcfg_rd_c = DATA_W'(deb_cfg_q);
`else
    assign deb_thresh  = '0;
    assign debcfg_rd_c = '0;
`endif

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        ext_pad_input_conditioner #(.DEB_W(DEB_W)) u_cond (
            .clk       (Clock),
            .rst_n     (Reset_N),
            .pad_y     (IO_Block_Y[p]),
            .deb_thresh(deb_thresh),
            .level     (level[p]),
            .rise_c    (rise_c[p])
        );
    end

    // Status/edge views cover pads 0..DATA_W-1; bits past NUM_PADS read 0.
    for (genvar i = 0; i < DATA_W; i++) begin : g_view
        if (i < NUM_PADS) begin : g_pad_bit
            assign status_c[i]   = level[i];
            assign edge_set_c[i] = rise_c[i];
        end else begin : g_zero_bit
            assign status_c[i]   = 1'b0;
            assign edge_set_c[i] = 1'b0;
        end
    end

    assign edge_clr_c = (wr_en_c && (a_c == EDGE_ADDR)) ? data_q : '0;

    // A rise in the clearing cycle keeps its flag set.
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            edge_q <= '0;
        end else begin
            edge_q <= (edge_q & ~edge_clr_c) | edge_set_c;
        end
    end

    always_comb begin
        drive_c = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            for (int v = 0; v < NUM_VEC; v++) begin
                if (out_cfg_q[p].sel == SEL_W'(v)) drive_c[p] = EXT_OutputsVectorSignals[v];
            end
        end
    end

    always_comb begin
        in_or_c = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (in_cfg_q[p].en && (in_cfg_q[p].dest == SEL_W'(i))) in_or_c[i] = in_or_c[i] | level[p];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            IO_Block_D              <= '0;
            IO_Block_E              <= '0;
            EXT_InputsVectorSignals <= '0;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                IO_Block_D[p] <= drive_c[p] ^ out_cfg_q[p].inv;
                IO_Block_E[p] <= out_cfg_q[p].oe;
            end
            EXT_InputsVectorSignals <= in_or_c;
        end
    end

endmodule

// File: tb/tb_ext_signals_router.sv
// Directed self-checking bench for ext_signals_router.
module tb_ext_signals_router;

    localparam int unsigned NUM_PADS = 10;
    localparam int unsigned NUM_VEC  = 32;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 8;
`ifdef EXT_IO_DEBOUNCE_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ext_signals_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [NUM_VEC-1:0]  vec_out;
    logic [NUM_VEC-1:0]  vec_in;
    logic [NUM_PADS-1:0] pd;
    logic [NUM_PADS-1:0] pe;
    logic [NUM_PADS-1:0] py;

    int n_tests = 0;
    int n_fail  = 0;

    ext_signals_router #(
        .NUM_PADS(NUM_PADS), .NUM_VEC(NUM_VEC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .Clock                   (clk),
        .Reset_N                 (rst_n),
        .cmd                     (bus),
        .EXT_OutputsVectorSignals(vec_out),
        .EXT_InputsVectorSignals (vec_in),
        .IO_Block_D              (pd),
        .IO_Block_E              (pe),
        .IO_Block_Y              (py)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [15:0] data,
                          output logic [15:0] rd);
        int n;
        @(negedge clk);
        bus.enable_cmd       = 1'b1;
        bus.write_read       = wr;
        bus.addr_frame       = addr;
        bus.write_data_frame = data;
        @(negedge clk);
        bus.enable_cmd = 1'b0;
        n = 0;
        while (bus.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("cmd_timeout", 32'(bus.busy), 32'd0);
        rd = bus.read_data_frame;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [15:0] data);
        logic [15:0] dummy;
        do_cmd(1'b1, addr, data, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [15:0] exp);
        logic [15:0] v;
        do_cmd(1'b0, addr, 16'h0, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        bus.enable_cmd       = 1'b0;
        bus.write_read       = 1'b0;
        bus.addr_frame       = '0;
        bus.write_data_frame = '0;
        vec_out              = '0;
        py                   = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_e",    32'(pe), 32'd0);
        check("rst_d",    32'(pd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rdat", 32'(bus.read_data_frame), 32'd0);
        check("rst_vin",  vec_in, 32'd0);
        rst_n = 1'b1;

`ifdef EXT_IO_DEBOUNCE_EN
        wr_reg(8'h82, 16'h0000);
`endif

        // ID read with exact busy timing
        @(negedge clk);
        bus.enable_cmd = 1'b1;
        bus.write_read = 1'b0;
        bus.addr_frame = 8'hFF;
        @(negedge clk);
        bus.enable_cmd = 1'b0;
        check("busy_c1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_c2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_c3", 32'(bus.busy), 32'd0);
        check("id_read", 32'(bus.read_data_frame), 32'hE510);

        // Output routing: pad3 <- vec[5]
        wr_reg(8'h03, 16'h0105);
        check("oe_pad3", 32'(pe), 32'h008);
        vec_out[5] = 1'b1;
        check("d3_pre",  32'(pd[3]), 32'd0);
        @(negedge clk);
        check("d3_rise", 32'(pd[3]), 32'd1);
        vec_out[5] = 1'b0;
        @(negedge clk);
        check("d3_fall", 32'(pd[3]), 32'd0);
        wr_reg(8'h03, 16'h0305);
        @(negedge clk);
        check("d3_inv",  32'(pd[3]), 32'd1);
        rd_check("outcfg3_rb", 8'h03, 16'h0305);

        // Out-of-range pad write
        wr_reg(8'h0C, 16'h01FF);
        rd_check("oor_read", 8'h0C, 16'h0000);
        check("oor_oe", 32'(pe), 32'h008);

        // Strobe held through busy: second command dropped
        @(negedge clk);
        bus.enable_cmd       = 1'b1;
        bus.write_read       = 1'b1;
        bus.addr_frame       = 8'h00;
        bus.write_data_frame = 16'h0101;
        @(negedge clk);
        bus.write_data_frame = 16'h01FF;
        @(negedge clk);
        @(negedge clk);
        bus.enable_cmd = 1'b0;
        repeat (2) @(negedge clk);
        rd_check("busy_drop", 8'h00, 16'h0101);
        check("oe_pad0", 32'(pe), 32'h009);

        // Input routing: pads 3 and 7 -> vec bit 28
        wr_reg(8'h43, 16'h011C);
        wr_reg(8'h47, 16'h011C);
        rd_check("incfg3_rb", 8'h43, 16'h011C);
        @(negedge clk);
        py[7] = 1'b1;
        repeat (2 + EXTRA) @(negedge clk);
        check("vin_lat",  vec_in, 32'd0);
        @(negedge clk);
        check("vin_p7",   vec_in, 32'h1000_0000);
        py[7] = 1'b0;
        repeat (6) @(negedge clk);
        check("vin_clr",  vec_in, 32'd0);
        py[3] = 1'b1;
        repeat (4 + EXTRA) @(negedge clk);
        check("vin_p3",   vec_in, 32'h1000_0000);
        py[3] = 1'b0;
        repeat (6) @(negedge clk);

        // Sticky rising-edge flags
        wr_reg(8'h81, 16'hFFFF);
        rd_check("edge_clr_all", 8'h81, 16'h0000);
        @(negedge clk);
        py[2] = 1'b1;
        repeat (5) @(negedge clk);
        rd_check("edge_p2",  8'h81, 16'h0004);
        rd_check("status_p2", 8'h80, 16'h0004);
        wr_reg(8'h81, 16'h0004);
        rd_check("edge_w1c", 8'h81, 16'h0000);
        py[2] = 1'b0;
        repeat (6) @(negedge clk);
        py[2] = 1'b1;
        repeat (EXTRA) @(negedge clk);
        wr_reg(8'h81, 16'h0004);
        rd_check("edge_set_wins", 8'h81, 16'h0004);

        // Debounce
`ifdef EXT_IO_DEBOUNCE_EN
        wr_reg(8'h82, 16'h0004);
        rd_check("debcfg_rb", 8'h82, 16'h0004);
        @(negedge clk);
        py[0] = 1'b1;
        repeat (3) @(negedge clk);
        py[0] = 1'b0;
        repeat (10) @(negedge clk);
        do_cmd(1'b0, 8'h80, 16'h0, v);
        check("deb_glitch", 32'(v[0]), 32'd0);
        py[0] = 1'b1;
        repeat (8) @(negedge clk);
        do_cmd(1'b0, 8'h80, 16'h0, v);
        check("deb_stable", 32'(v[0]), 32'd1);
`else
        wr_reg(8'h82, 16'h0004);
        rd_check("debcfg_off", 8'h82, 16'h0000);
        do_cmd(1'b0, 8'h80, 16'h0, v);
        check("status_pass", 32'(v), 32'h0004);
`endif

        // Reset during EXEC aborts the write
        @(negedge clk);
        bus.enable_cmd       = 1'b1;
        bus.write_read       = 1'b1;
        bus.addr_frame       = 8'h01;
        bus.write_data_frame = 16'h0105;
        @(negedge clk);
        bus.enable_cmd = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_e",    32'(pe), 32'd0);
        check("mid_d",    32'(pd), 32'd0);
        check("mid_rdat", 32'(bus.read_data_frame), 32'd0);
        check("mid_vin",  vec_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        py    = '0;
        rd_check("mid_nowr", 8'h01, 16'h0000);
        rd_check("mid_cfg3", 8'h03, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
